// File: rtl/mac_pkg.sv
// Shared definitions for the MAC transmit/receive datapath:
// framing constants, CRC-32 parameters and the transmit FSM state type.
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        DRAIN,
        IFG
    } mac_tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step: current CRC plus one byte, LSB first.
// Shared by the transmit framer and the receive FCS checker.
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
    end

    assign crc_next = c;

endmodule

// File: rtl/mac_tx_framer.sv
// Byte-wide Ethernet transmit framer: preamble, SFD, payload, pad, FCS, IFG.
// Define MAC_TX_PAD_EN to zero-pad payloads shorter than MIN_PAYLOAD.
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int MIN_PAYLOAD    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       mac_phy_txen,
    output logic [7:0] mac_phy_txd,
    output logic       tx_busy,
    output logic       tx_underrun
);

`ifdef MAC_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    mac_tx_state_t state;
    logic [10:0]   cnt;
    logic [10:0]   cnt_inc;
    logic [1:0]    fcs_idx;
    logic [31:0]   crc;
    logic [31:0]   crc_next;
    logic [31:0]   fcs_word;
    logic [7:0]    crc_data;
    logic          bad;

    assign s_ready  = (state == SFD) || (state == DATA) || (state == DRAIN);
    assign crc_data = (state == PAD) ? 8'h00 : s_data;
    assign cnt_inc  = (cnt == 11'h7ff) ? cnt : cnt + 11'd1;
    // An aborted frame sends the raw register so the far end sees a bad FCS.
    assign fcs_word = bad ? crc : ~crc;

    crc32_d8 u_crc (
        .crc      (crc),
        .data     (crc_data),
        .crc_next (crc_next)
    );

    // State names the action taken at the next edge; outputs hold the current byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            fcs_idx      <= '0;
            crc          <= '0;
            bad          <= 1'b0;
            mac_phy_txen <= 1'b0;
            mac_phy_txd  <= '0;
            tx_busy      <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        state        <= PREAMBLE;
                        cnt          <= 11'd1;
                        bad          <= 1'b0;
                        tx_busy      <= 1'b1;
                        mac_phy_txen <= 1'b1;
                        mac_phy_txd  <= PREAMBLE_BYTE;
                    end
                end
                PREAMBLE: begin
                    if (cnt == 11'(PREAMBLE_BYTES)) begin
                        state       <= SFD;
                        cnt         <= '0;
                        crc         <= CRC_INIT;
                        mac_phy_txd <= SFD_BYTE;
                    end else begin
                        cnt         <= cnt_inc;
                        mac_phy_txd <= PREAMBLE_BYTE;
                    end
                end
                SFD, DATA: begin
                    if (s_valid) begin
                        mac_phy_txd <= s_data;
                        crc         <= crc_next;
                        cnt         <= cnt_inc;
                        fcs_idx     <= 2'd0;
                        if (!s_last)
                            state <= DATA;
                        else if (PAD_ON && cnt_inc < 11'(MIN_PAYLOAD))
                            state <= PAD;
                        else
                            state <= FCS;
                    end else begin
                        // Underrun: first FCS byte goes out now, uncomplemented.
                        tx_underrun <= 1'b1;
                        bad         <= 1'b1;
                        mac_phy_txd <= crc[7:0];
                        fcs_idx     <= 2'd1;
                        state       <= FCS;
                    end
                end
                PAD: begin
                    mac_phy_txd <= 8'h00;
                    crc         <= crc_next;
                    cnt         <= cnt_inc;
                    if (cnt_inc >= 11'(MIN_PAYLOAD))
                        state <= FCS;
                end
                FCS: begin
                    mac_phy_txd <= 8'(fcs_word >> {fcs_idx, 3'b000});
                    fcs_idx     <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        state <= bad ? DRAIN : IFG;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    mac_phy_txen <= 1'b0;
                    mac_phy_txd  <= '0;
                    if (s_valid && s_last) begin
                        state <= IFG;
                        cnt   <= '0;
                    end
                end
                IFG: begin
                    mac_phy_txen <= 1'b0;
                    mac_phy_txd  <= '0;
                    if (cnt == 11'(IFG_BYTES)) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule
